// File: rtl/fp_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_div_pkg
// Purpose  : Shared types, constants and the operand classifier used by the
//            divider scheduler and its special-operand resolver.
// Revision : 1.0  initial release
// ============================================================================
package fp_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } fp_class_t;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  // Bit positions inside resp_flags = {timeout, invalid, div_by_zero}
  localparam int FLAG_DBZ = 0;
  localparam int FLAG_INV = 1;
  localparam int FLAG_TO  = 2;

  // Denormals (exponent 0, any mantissa) classify as ZERO: they are flushed.
  function automatic fp_class_t fp_classify(input logic [31:0] x);
    fp_class_t c;
    if (x[30:23] == 8'hFF) begin
      c = (x[22:0] == 23'd0) ? INF : NAN;
    end else if (x[30:23] == 8'h00) begin
      c = ZERO;
    end else begin
      c = NORM;
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_div_special.sv
`default_nettype none
// ============================================================================
// Module   : fp_div_special
// Purpose  : Combinational resolver for operand pairs whose quotient does not
//            need the iterative core (NaN, zero, infinity, denormal inputs).
// Revision : 1.0  initial release
// ============================================================================
module fp_div_special (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        is_special,
  output logic [31:0] result,
  output logic [2:0]  flags
);
  import fp_div_pkg::*;

  fp_class_t w_ca;
  fp_class_t w_cb;
  logic      w_sgn;

  // Classify both operands and pick the fixed result for every non-NORM/NORM pair.
  always_comb begin
    w_ca       = fp_classify(a);
    w_cb       = fp_classify(b);
    w_sgn      = a[31] ^ b[31];
    is_special = 1'b1;
    result     = 32'd0;
    flags      = 3'b000;
    if (w_ca == NAN || w_cb == NAN ||
        (w_ca == ZERO && w_cb == ZERO) ||
        (w_ca == INF  && w_cb == INF)) begin
      result          = QNAN;
      flags[FLAG_INV] = 1'b1;
    end else if (w_ca == NORM && w_cb == ZERO) begin
      result          = {w_sgn, POS_INF[30:0]};
      flags[FLAG_DBZ] = 1'b1;
    end else if (w_ca == INF) begin
      // b is finite here (zero or normal): infinity without a flag
      result = {w_sgn, POS_INF[30:0]};
    end else if (w_ca == ZERO || w_cb == INF) begin
      result = {w_sgn, 31'd0};
    end else begin
      is_special = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_div_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fp_div_scheduler
// Purpose  : Round-robin scheduler sharing one iterative FP32 divider among
//            NUM_REQ requesters, with local special-operand resolution,
//            a WAIT timeout and an ID-tagged registered response.
// Revision : 1.0  initial release
// ============================================================================
module fp_div_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_result,
  output logic [ID_W-1:0]       resp_id,
  output logic [2:0]            resp_flags,
  output logic                  div_start,
  output logic [31:0]           div_a,
  output logic [31:0]           div_b,
  input  logic                  div_done,
  input  logic [31:0]           div_result
);
  import fp_div_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  sched_state_t      r_state;
  sched_state_t      w_next_state;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   w_gnt;
  logic [ID_W-1:0]   w_next_ptr;
  logic              w_found;
  logic              w_accept;
  logic [31:0]       w_sel_a;
  logic [31:0]       w_sel_b;
  logic              w_spec_is;
  logic [31:0]       w_spec_result;
  logic [2:0]        w_spec_flags;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_cnt_hit;
  logic              r_resp_valid;
  logic [31:0]       r_resp_result;
  logic [ID_W-1:0]   r_resp_id;
  logic [2:0]        r_resp_flags;

  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // Round-robin search: scan from the highest offset down so the nearest valid requester wins.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[rr_index(r_ptr, k)]) begin
        w_found = 1'b1;
        w_gnt   = rr_index(r_ptr, k);
      end
    end
  end

  assign w_accept   = (r_state == IDLE) && w_found && !rst;
  assign w_next_ptr = (w_gnt == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt + ID_W'(1);
  assign w_cnt_hit  = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // One-hot ready for the granted requester, only in the accept cycle.
  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready[w_gnt] = 1'b1;
  end

  // Operand mux for the granted requester.
  always_comb begin
    w_sel_a = 32'd0;
    w_sel_b = 32'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt == ID_W'(i)) begin
        w_sel_a = req_a[32*i +: 32];
        w_sel_b = req_b[32*i +: 32];
      end
    end
  end

  fp_div_special u_special (
    .a          (w_sel_a),
    .b          (w_sel_b),
    .is_special (w_spec_is),
    .result     (w_spec_result),
    .flags      (w_spec_flags)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = w_spec_is ? RESP : ISSUE;
      ISSUE:   w_next_state = WAIT;
      WAIT:    if (div_done || w_cnt_hit) w_next_state = RESP;
      RESP:    if (resp_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Capture, timeout counting and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr         <= '0;
      r_a           <= 32'd0;
      r_b           <= 32'd0;
      r_cnt         <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_result <= 32'd0;
      r_resp_id     <= '0;
      r_resp_flags  <= 3'b000;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_ptr     <= w_next_ptr;
            r_resp_id <= w_gnt;
            r_a       <= w_sel_a;
            r_b       <= w_sel_b;
            r_cnt     <= '0;
            if (w_spec_is) begin
              r_resp_valid  <= 1'b1;
              r_resp_result <= w_spec_result;
              r_resp_flags  <= w_spec_flags;
            end
          end
        end
        ISSUE: r_cnt <= r_cnt + CNT_W'(1);
        WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // A completion on the limit cycle still wins over the timeout.
          if (div_done) begin
            r_resp_valid  <= 1'b1;
            r_resp_result <= div_result;
            r_resp_flags  <= 3'b000;
          end else if (w_cnt_hit) begin
            r_resp_valid           <= 1'b1;
            r_resp_result          <= QNAN;
            r_resp_flags           <= 3'b000;
            r_resp_flags[FLAG_TO]  <= 1'b1;
            r_resp_flags[FLAG_INV] <= 1'b1;
          end
        end
        RESP: if (resp_ready) r_resp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign div_start   = (r_state == ISSUE);
  assign div_a       = (r_state == ISSUE || r_state == WAIT) ? r_a : 32'd0;
  assign div_b       = (r_state == ISSUE || r_state == WAIT) ? r_b : 32'd0;
  assign resp_valid  = r_resp_valid;
  assign resp_result = r_resp_result;
  assign resp_id     = r_resp_id;
  assign resp_flags  = r_resp_flags;

endmodule
`default_nettype wire
